// File: rtl/frame_buffer_write_ctrl_if.sv
// Pixel-in / write-out bundle for the frame-buffer write controller.
// slave is the controller side, master the capture/memory side.
interface frame_buffer_write_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [15:0]           resolution_width_i;
  logic [15:0]           resolution_depth_i;
  logic                  frame_start_i;
  logic                  pixel_valid_i;
  logic [DATA_WIDTH-1:0] pixel_data_i;
  logic                  pixel_ready_o;
  logic                  wr_stall_i;
  logic                  wr_o;
  logic [ADDR_WIDTH-1:0] addr_wr_o;
  logic [DATA_WIDTH-1:0] data_wr_o;
  logic                  page_written_once_o;
  logic                  frame_done_o;
  logic                  frame_err_o;

  modport slave (
    input  resolution_width_i, resolution_depth_i, frame_start_i,
    input  pixel_valid_i, pixel_data_i, wr_stall_i,
    output pixel_ready_o, wr_o, addr_wr_o, data_wr_o,
    output page_written_once_o, frame_done_o, frame_err_o
  );

  modport master (
    output resolution_width_i, resolution_depth_i, frame_start_i,
    output pixel_valid_i, pixel_data_i, wr_stall_i,
    input  pixel_ready_o, wr_o, addr_wr_o, data_wr_o,
    input  page_written_once_o, frame_done_o, frame_err_o
  );
endinterface

// File: rtl/frame_buffer_write_ctrl.sv
// Single-page frame-buffer writer: one write per accepted pixel at linear
// pixel-index addresses, with frame-done, sticky page-written and restart error.
module frame_buffer_write_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  frame_buffer_write_ctrl_if.slave  bus
);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [31:0]           r_total;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_page;
  logic                  r_done;
  logic                  r_err;

  logic [31:0] w_total;
  logic        w_dims_ok;
  logic        w_ready;
  logic        w_accept;
  logic        w_last;

  assign w_total   = {16'd0, bus.resolution_width_i} * {16'd0, bus.resolution_depth_i};
  assign w_dims_ok = (bus.resolution_width_i != 16'd0) && (bus.resolution_depth_i != 16'd0);
  assign w_ready   = (r_state == StWrite) && !bus.wr_stall_i;
  assign w_accept  = w_ready && bus.pixel_valid_i;
  assign w_last    = w_accept && (r_count == ADDR_WIDTH'(r_total - 32'd1));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= StIdle;
      r_count <= '0;
      r_total <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_page  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.frame_start_i && w_dims_ok) begin
            r_state <= StWrite;
            r_count <= '0;
            r_total <= w_total;
          end
        end
        StWrite: begin
          if (w_last) begin
            r_wr    <= 1'b1;
            r_addr  <= r_count;
            r_data  <= bus.pixel_data_i;
            r_done  <= 1'b1;
            r_page  <= 1'b1;
            r_count <= '0;
            // A start coinciding with the last pixel chains straight into the next frame.
            if (bus.frame_start_i && w_dims_ok) begin
              r_total <= w_total;
            end else begin
              r_state <= StIdle;
            end
          end else if (bus.frame_start_i) begin
            // Restart: any pixel accepted this cycle belongs to the abandoned frame.
            r_err   <= 1'b1;
            r_count <= '0;
            if (w_dims_ok) begin
              r_total <= w_total;
            end else begin
              r_state <= StIdle;
            end
          end else if (w_accept) begin
            r_wr    <= 1'b1;
            r_addr  <= r_count;
            r_data  <= bus.pixel_data_i;
            r_count <= r_count + ADDR_WIDTH'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.pixel_ready_o       = w_ready;
  assign bus.wr_o                = r_wr;
  assign bus.addr_wr_o           = r_addr;
  assign bus.data_wr_o           = r_data;
  assign bus.page_written_once_o = r_page;
  assign bus.frame_done_o        = r_done;
  assign bus.frame_err_o         = r_err;

endmodule

// File: tb/tb_frame_buffer_write_ctrl.sv
// Directed bench for frame_buffer_write_ctrl: a negedge monitor logs every write,
// and each test step compares the log and outputs against hand-derived values.
module tb_frame_buffer_write_ctrl;

  logic clk;
  logic resetn;

  frame_buffer_write_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) bus ();

  frame_buffer_write_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    int          cyc;
    logic        page;
    logic        err;
  } wr_t;

  wr_t         q[$];
  int          cyc_n = 0;
  int          done_cnt = 0;
  logic [31:0] done_addr = '0;
  logic        done_page = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (bus.wr_o === 1'b1) begin
      q.push_back('{addr: bus.addr_wr_o, data: bus.data_wr_o, cyc: cyc_n,
                    page: bus.page_written_once_o, err: bus.frame_err_o});
    end
    if (bus.frame_done_o === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_addr = bus.addr_wr_o;
      done_page = bus.page_written_once_o;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_seq(input string tag, input int first, input int n,
                           input int addr0, input int data0);
    int bad = 0;
    if (q.size() < first + n) begin
      bad = n;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (q[first+k].addr !== 32'(addr0 + k) || q[first+k].data !== 16'(data0 + k))
          bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_wr"},    bus.wr_o, 0);
    check({pfx, "_addr"},  bus.addr_wr_o, 0);
    check({pfx, "_data"},  bus.data_wr_o, 0);
    check({pfx, "_ready"}, bus.pixel_ready_o, 0);
    check({pfx, "_page"},  bus.page_written_once_o, 0);
    check({pfx, "_done"},  bus.frame_done_o, 0);
    check({pfx, "_err"},   bus.frame_err_o, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q.delete();
    done_cnt = 0;
  endtask

  task automatic start_frame(input int w, input int d);
    bus.resolution_width_i = 16'(w);
    bus.resolution_depth_i = 16'(d);
    bus.frame_start_i = 1'b1;
    cyc();
    bus.frame_start_i = 1'b0;
  endtask

  // Streams n pixels (data base+i), optionally stalling, pulsing frame_start or resetting.
  task automatic stream(input int n, input int base, input int stall_at, input int stall_len,
                        input int start_at, input int rst_at);
    int i = 0;
    int scnt = 0;
    bit started = 0;
    bus.pixel_valid_i = 1'b1;
    while (i < n) begin
      bus.pixel_data_i  = 16'(base + i);
      bus.wr_stall_i    = (i == stall_at) && (scnt < stall_len);
      bus.frame_start_i = (i == start_at) && !started;
      if (i == rst_at) begin
        #2;
        check("pre_reset_wr", bus.wr_o, 1);
        resetn = 1'b0;
        #1;
        check_zero("async_rst");
        bus.pixel_valid_i = 1'b0;
        bus.frame_start_i = 1'b0;
        bus.wr_stall_i = 1'b0;
        return;
      end
      if (bus.wr_stall_i && scnt == 0) begin
        #1;
        check("ready_in_stall", bus.pixel_ready_o, 0);
      end
      if (i == 5 && !bus.wr_stall_i) check("ready_in_write", bus.pixel_ready_o, 1);
      cyc();
      if (bus.frame_start_i) begin
        started = 1;
        bus.frame_start_i = 1'b0;
        if (i < n - 1) i = 0;
        else i++;
      end else if (!bus.wr_stall_i) begin
        i++;
      end else begin
        scnt++;
      end
    end
    bus.pixel_valid_i = 1'b0;
    bus.wr_stall_i = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    bus.resolution_width_i = '0;
    bus.resolution_depth_i = '0;
    bus.frame_start_i = 1'b0;
    bus.pixel_valid_i = 1'b0;
    bus.pixel_data_i = '0;
    bus.wr_stall_i = 1'b0;
    #3;
    check_zero("reset");
    cyc();
    cyc();
    resetn = 1'b1;
    cyc();

    // Idle: pixels offered without a start, then a zero-width start.
    bus.pixel_valid_i = 1'b1;
    bus.pixel_data_i = 16'h0055;
    cyc(); cyc(); cyc();
    check("idle_ready", bus.pixel_ready_o, 0);
    check("idle_writes", q.size(), 0);
    bus.pixel_valid_i = 1'b0;
    start_frame(0, 4);
    bus.pixel_valid_i = 1'b1;
    cyc(); cyc(); cyc();
    check("w0_ready", bus.pixel_ready_o, 0);
    check("w0_writes", q.size(), 0);
    bus.pixel_valid_i = 1'b0;

    // Full 10x4 frame; resolution inputs change mid-frame and must be ignored.
    clear_log();
    start_frame(10, 4);
    bus.resolution_width_i = 16'd3;
    bus.resolution_depth_i = 16'd3;
    stream(40, 'h100, -1, 0, -1, -1);
    cyc(); cyc();
    check("f1_count", q.size(), 40);
    check_seq("f1_seq", 0, 40, 0, 'h100);
    check("f1_contig", (q.size() == 40) ? q[39].cyc - q[0].cyc : -1, 39);
    check("f1_done_cnt", done_cnt, 1);
    check("f1_done_addr", done_addr, 39);
    check("f1_done_page", done_page, 1);
    check("f1_page_no_early", (q.size() == 40) ? q[38].page : 1'bx, 0);
    check("f1_err", bus.frame_err_o, 0);
    check("f1_idle_ready", bus.pixel_ready_o, 0);

    // Stall for 10 cycles before pixel 20.
    clear_log();
    start_frame(10, 4);
    stream(40, 'h200, 20, 10, -1, -1);
    cyc(); cyc();
    check("stall_count", q.size(), 40);
    check_seq("stall_seq", 0, 40, 0, 'h200);
    check("stall_gap", (q.size() == 40) ? q[20].cyc - q[19].cyc : -1, 11);
    check("stall_done_cnt", done_cnt, 1);

    // frame_start coincident with the last-pixel accept chains into a new frame.
    clear_log();
    start_frame(10, 4);
    stream(40, 'h300, -1, 0, 39, -1);
    stream(3, 'h400, -1, 0, -1, -1);
    cyc(); cyc();
    check("coin_count", q.size(), 43);
    check_seq("coin_seq_a", 0, 40, 0, 'h300);
    check_seq("coin_seq_b", 40, 3, 0, 'h400);
    check("coin_done_cnt", done_cnt, 1);
    check("coin_err", bus.frame_err_o, 0);

    // Early restart at pixel 15 after a fresh reset.
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    check("rst2_page", bus.page_written_once_o, 0);
    clear_log();
    start_frame(10, 4);
    stream(40, 'h500, -1, 0, 15, -1);
    cyc(); cyc();
    check("rs_count", q.size(), 55);
    check_seq("rs_seq_a", 0, 15, 0, 'h500);
    check_seq("rs_seq_b", 15, 40, 0, 'h500);
    check("rs_gap", (q.size() == 55) ? q[15].cyc - q[14].cyc : -1, 2);
    check("rs_err_after", (q.size() == 55) ? q[15].err : 1'bx, 1);
    check("rs_page_after", (q.size() == 55) ? q[15].page : 1'bx, 0);
    check("rs_done_cnt", done_cnt, 1);
    check("rs_done_addr", done_addr, 39);
    check("rs_err_final", bus.frame_err_o, 1);
    check("rs_page_final", bus.page_written_once_o, 1);

    // Asynchronous reset mid-frame at pixel 25, then recovery.
    clear_log();
    start_frame(10, 4);
    stream(40, 'h600, -1, 0, -1, 25);
    cyc();
    resetn = 1'b1;
    clear_log();
    bus.pixel_valid_i = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("post_rst_ready", bus.pixel_ready_o, 0);
    check("post_rst_writes", q.size(), 0);
    bus.pixel_valid_i = 1'b0;
    start_frame(2, 2);
    stream(4, 'h700, -1, 0, -1, -1);
    cyc(); cyc();
    check("small_count", q.size(), 4);
    check_seq("small_seq", 0, 4, 0, 'h700);
    check("small_done_cnt", done_cnt, 1);
    check("small_done_addr", done_addr, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
